// File: rtl/uart_pkg.sv
// Shared types, constants and the baud-rate table for the UART transmit path.
package uart_pkg;

   localparam int unsigned FRAME_BITS = 11;
   localparam int unsigned BT_W       = 19;

   typedef enum logic {
      IDLE,
      SHIFT
   } state_t;

   // Bit-time terminal count N; one bit lasts N+1 clocks at 100 MHz.
   function automatic logic [BT_W-1:0] baud_n(input logic [3:0] sel);
      logic [BT_W-1:0] n;
      case (sel)
         4'd0:    n = 19'd333333;
         4'd1:    n = 19'd83333;
         4'd2:    n = 19'd41667;
         4'd3:    n = 19'd20833;
         4'd4:    n = 19'd10417;
         4'd5:    n = 19'd5208;
         4'd6:    n = 19'd2604;
         4'd7:    n = 19'd1736;
         4'd8:    n = 19'd868;
         4'd9:    n = 19'd434;
         4'd10:   n = 19'd217;
         4'd11:   n = 19'd109;
         default: n = '0;
      endcase
      return n;
   endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-time counter: btu marks the last clock of each bit-time while doit is high.
module uart_bit_timer
   import uart_pkg::*;
(
   input  logic            clk,
   input  logic            reset,
   input  logic            doit,
   input  logic [BT_W-1:0] n,
   output logic            btu
);

   logic [BT_W-1:0] count;

   assign btu = (count == n);

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         count <= '0;
      else if (!doit || btu)
         count <= '0;
      else
         count <= count + 1'b1;
   end

endmodule

// File: rtl/uart_tx_sequencer.sv
// UART transmit controller: accepts a byte, builds an 11-bit frame and shifts it out LSB-first.
module uart_tx_sequencer
   import uart_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] baud_val,
   input  logic       eight,
   input  logic       pen,
   input  logic       ohel,
   input  logic [7:0] tx_data,
   input  logic       tx_start,
   output logic       tx_ready,
   output logic       tx_done,
   output logic       tx
);

   state_t                  state, state_nxt;
   logic [FRAME_BITS-1:0]   sreg;
   logic [FRAME_BITS-1:0]   frame;
   logic [3:0]              bit_count;
   logic [3:0]              baud_q;
   logic                    doit;
   logic                    btu;
   logic                    accept;
   logic [7:0]              data_act;
   logic                    par_bit;

   uart_bit_timer u_timer (
      .clk   (clk),
      .reset (reset),
      .doit  (doit),
      .n     (baud_n(baud_q)),
      .btu   (btu)
   );

   // Parity covers only the active data bits; unused slots fill with stop level.
   always_comb begin
      data_act = eight ? tx_data : {1'b0, tx_data[6:0]};
      par_bit  = pen ? (ohel ? ~^data_act : ^data_act) : 1'b1;
      if (eight)
         frame = {1'b1, par_bit, tx_data, 1'b0};
      else
         frame = {2'b11, par_bit, tx_data[6:0], 1'b0};
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      tx_ready  = 1'b0;
      tx_done   = 1'b0;
      doit      = 1'b0;
      accept    = 1'b0;
      case (state)
         IDLE: begin
            tx_ready = 1'b1;
            if (tx_start) begin
               accept    = 1'b1;
               state_nxt = SHIFT;
            end
         end
         SHIFT: begin
            doit = 1'b1;
            if (btu && bit_count == 4'(FRAME_BITS - 1)) begin
               tx_done   = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sreg      <= '1;
         bit_count <= '0;
         baud_q    <= '0;
      end else if (accept) begin
         sreg      <= frame;
         bit_count <= '0;
         baud_q    <= baud_val;
      end else if (doit && btu) begin
         sreg      <= {1'b1, sreg[FRAME_BITS-1:1]};
         bit_count <= tx_done ? '0 : bit_count + 1'b1;
      end
   end

   assign tx = sreg[0];

endmodule

// File: doc/uart_tx_sequencer.md
# uart_tx_sequencer

Transmit-side controller for the UART. It accepts a byte on a ready/start handshake and builds an 11-bit frame: start bit, 7 or 8 data bits, optional parity, then stop/idle padding. It runs the bit-time counter with a DOIT enable and shifts the frame out LSB-first, one bit per bit-time tick (BTU). It sits between the host-side transmit register and the serial TX pin.

## Interface
- No parameters. Frame width is fixed at 11 bit-times.
- clk  in  1  system clock (100 MHz nominal)
- reset  in  1  reset, asynchronous, active-high
- baud_val  in  4  baud select, latched at frame accept
- eight  in  1  1 = 8 data bits; 0 = 7 data bits (tx_data[7] ignored); latched at accept
- pen  in  1  parity enable; latched at accept
- ohel  in  1  parity polarity: 1 = odd, 0 = even; latched at accept
- tx_data  in  8  byte to send; latched at accept
- tx_start  in  1  request; honoured only in a cycle where tx_ready=1
- tx_ready  out  1  idle and able to accept
- tx_done  out  1  one-cycle pulse at end of frame
- tx  out  1  serial line; idles high

## Operation
- Reset values:
  - tx=1, tx_ready=1, tx_done=0.
  - State IDLE; shift register all ones; bit_count=0; bit-time counter=0.
- States:
  - IDLE: tx_ready=1, DOIT=0. On tx_start go to SHIFT.
  - SHIFT: tx_ready=0, DOIT=1.
- Accept (IDLE and tx_start):
  - Latch baud_val.
  - Load shift register sreg[10:0]; bit_count=0; next state SHIFT.
- Frame layout, sreg[0] sent first:
  - sreg[0] = 0 (start bit).
  - eight=1: [8:1]=tx_data[7:0], [9]=par if pen else 1, [10]=1.
  - eight=0: [7:1]=tx_data[6:0], [8]=par if pen else 1, [10:9]=1.
  - par = ohel ? ~^d : ^d, where d covers the active data bits only.
- tx = sreg[0] at all times.
- On each BTU in SHIFT: sreg <= {1'b1, sreg[10:1]}; bit_count++.
- On the BTU with bit_count==10:
  - Return to IDLE; tx_done=1 for that cycle; bit_count=0; DOIT drops.
  - sreg is all ones, so tx=1.
- tx_start while tx_ready=0 is ignored, not queued.
- Changes to tx_data and config inputs during SHIFT have no effect.

## Timing
- Bit-time counter:
  - 19-bit count, cleared whenever DOIT=0 or BTU=1, else incremented.
  - BTU = (count == N).
  - One bit-time = N+1 clocks.
- N by baud_val 0..11: 333333, 83333, 41667, 20833, 10417, 5208, 2604, 1736, 868, 434, 217, 109. baud_val 12..15 gives N=0.
- Accept at edge k:
  - tx falls to 0 and tx_ready falls after edge k.
  - The first BTU is asserted N cycles later.
- Frame duration, from the accept edge to the edge where tx_ready=1 again: 11·(N+1) clocks.
- tx_done is high during the final cycle of SHIFT. tx_ready rises on the following edge.
- Back-to-back: tx_start held high gives the next accept 1 cycle after tx_ready rises. The idle gap is 1 clock.
- Reset mid-frame: outputs return to reset values immediately (asynchronous). No partial tx_done.

## Structure
- Package uart_pkg holds:
  - the baud table function (baud_val -> 19-bit N);
  - the state enum {IDLE, SHIFT};
  - constants FRAME_BITS=11 and BT_W=19.
- Sub-module uart_bit_timer: inputs clk, reset, doit, n[18:0]; output btu. Counter semantics as in Timing.
- The top holds the FSM, config latch, parity generation, shift register and 4-bit bit_count.

## Test plan
- 8N1, tx_data=0x55, baud_val=11 (N=109):
  - tx = 0,1,0,1,0,1,0,1,0,1,1, each bit 110 clocks.
  - tx_done at clock 1209 after accept; tx_ready rises at 1210.
- 8-bit, pen=1, 0x07: ohel=0 gives parity bit 1; ohel=1 gives parity bit 0.
- 7-bit, pen=1, ohel=0, tx_data=0x81:
  - Data bits 1,0,0,0,0,0,0; parity 1; then 1,1.
  - Bit 7 of tx_data has no effect.
- baud_val=15 (N=0), 0xA5:
  - Each bit lasts 1 clock; frame is 11 clocks.
  - tx_start held high: second start bit appears 12 clocks after the first.
- tx_start pulsed mid-frame, with tx_data and baud_val changed mid-frame: current frame is unaltered, no second frame, tx_done fires once.
- reset asserted at bit 5 of a frame:
  - tx=1, tx_ready=1, tx_done=0 within the same cycle.
  - After release, a new 0x3C frame transmits correctly.
